// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types and constants for the TDC framing core
package tdc_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, LOAD, SEND} state_t;
  localparam logic [7:0] HEADER_DEFAULT = 8'hAF;
  localparam logic [2:0] ST_RSVD = 3'b000;
  localparam int ST_SEQ_W = 4;
  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction
endpackage

// File: rtl/tdc_edge_sync.sv
// tdc_edge_sync: multi-flop synchroniser with single-cycle rising-edge pulse
module tdc_edge_sync #(
  parameter int SYNC_N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic [SYNC_N-1:0] s;
  logic h;
  always_ff @(posedge clk)
    if (!rst) begin
      s <= '0;
      h <= 1'b0;
    end else begin
      s <= {s[SYNC_N-2:0], d};
      h <= s[SYNC_N-1];
    end
  assign rise = s[SYNC_N-1] & ~h;
endmodule

// File: rtl/tdc_frame_tx.sv
// tdc_frame_tx: start/stop interval counter streaming framed results as bytes
module tdc_frame_tx
  import tdc_pkg::*;
#(
  parameter int          CNT_W  = 16,
  parameter logic [7:0]  HEADER = HEADER_DEFAULT,
  parameter int          SYNC_N = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] axi_data,
  output logic       axi_valid,
  input  logic       axi_ready,
  output logic       busy,
  output logic       overflow,
  output logic       missed
);
  localparam int NB = nbytes(CNT_W);
  localparam int FW = (NB + 2) * 8;
  localparam int IW = $clog2(NB + 2);
  localparam logic [IW-1:0] LAST = IW'(NB + 1);
  logic start_rise, stop_rise;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [NB*8-1:0] cz;
  logic ovf;
  logic [ST_SEQ_W-1:0] seq;
  logic [IW-1:0] idx;
  logic [FW-1:0] sr;
  tdc_edge_sync #(.SYNC_N(SYNC_N)) u_start (.clk(clk), .rst(rst), .d(start), .rise(start_rise));
  tdc_edge_sync #(.SYNC_N(SYNC_N)) u_stop  (.clk(clk), .rst(rst), .d(stop),  .rise(stop_rise));
  always_comb begin
    cz = '0;
    cz[CNT_W-1:0] = cnt;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ovf       <= 1'b0;
      seq       <= '0;
      idx       <= '0;
      sr        <= '0;
      axi_data  <= '0;
      axi_valid <= 1'b0;
      overflow  <= 1'b0;
      missed    <= 1'b0;
    end else begin
      if (start_rise && state != IDLE) missed <= 1'b1;
      case (state)
        IDLE:
          if (start_rise) begin
            cnt      <= CNT_W'(1);
            overflow <= 1'b0;
            state    <= COUNT;
          end
        COUNT:
          if (stop_rise) begin
            ovf   <= 1'b0;
            state <= LOAD;
          end else if (&cnt) begin
            ovf   <= 1'b1;
            state <= LOAD;
          end else cnt <= cnt + 1'b1;
        LOAD: begin
          sr        <= {HEADER, cz, ovf, ST_RSVD, seq};
          overflow  <= ovf;
          idx       <= '0;
          axi_data  <= HEADER;
          axi_valid <= 1'b1;
          state     <= SEND;
        end
        SEND:
          if (axi_ready) begin
            if (idx == LAST) begin
              axi_valid <= 1'b0;
              axi_data  <= '0;
              seq       <= seq + 1'b1;
              state     <= IDLE;
            end else begin
              idx      <= idx + 1'b1;
              sr       <= sr << 8;
              axi_data <= sr[FW-9 -: 8];
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tdc_frame_tx.sv
// tb_tdc_frame_tx: scoreboard bench for tdc_frame_tx (16-bit and 8-bit counters)
module tb_tdc_frame_tx;
  logic clk = 0, rst = 0, start = 0, stop = 0, ready = 1;
  logic start8 = 0, stop8 = 0, ready8 = 1;
  logic [7:0] data, data8;
  logic valid, busy, ovf, missed, valid8, busy8, ovf8, missed8;
  int checks = 0, failures = 0;
  logic [7:0] q[$], qb[$];
  logic [3:0] seq_a = 0, seq_b = 0;
  logic pv = 0, pr = 0;
  logic [7:0] pd = 0;
  typedef struct {int k; logic [7:0] hi; logic [7:0] lo;} vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  tdc_frame_tx dut (.clk(clk), .rst(rst), .start(start), .stop(stop), .axi_data(data),
    .axi_valid(valid), .axi_ready(ready), .busy(busy), .overflow(ovf), .missed(missed));
  tdc_frame_tx #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .stop(stop8), .axi_data(data8),
    .axi_valid(valid8), .axi_ready(ready8), .busy(busy8), .overflow(ovf8), .missed(missed8));

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
    end
  endtask

  task automatic timeout(input string n);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", n, $time);
  endtask

  function automatic void push_a(input logic [7:0] hi, input logic [7:0] lo);
    q.push_back(8'hAF); q.push_back(hi); q.push_back(lo); q.push_back({4'b0000, seq_a});
    seq_a++;
  endfunction

  function automatic void push_b(input logic o);
    qb.push_back(8'hAF); qb.push_back(8'hFF); qb.push_back({o, 3'b000, seq_b});
    seq_b++;
  endfunction

  always @(negedge clk) begin
    if (!rst) pv = 0;
    else begin
      if (pv && !pr) begin
        chk("hold_valid", valid, 1);
        chk("hold_data", data, pd);
      end
      if (!valid) chk("idle_data", data, 0);
      else if (ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_byte got=%0h exp=none t=%0t", data, $time);
        end else chk("byte", data, q.pop_front());
      end
      pv = valid; pr = ready; pd = data;
    end
  end

  always @(negedge clk)
    if (rst && valid8) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_byte8 got=%0h exp=none t=%0t", data8, $time);
      end else chk("byte8", data8, qb.pop_front());
    end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 ready = r;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (valid) return;
    end
    timeout("wait_valid");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (!busy && q.size() == 0) return;
    end
    timeout("wait_idle");
  endtask

  task automatic wait_idle_b();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy8 && qb.size() == 0) return;
    end
    timeout("wait_idle_b");
  endtask

  task automatic run_frame(input int k, input logic [7:0] hi, input logic [7:0] lo);
    @(negedge clk) start = 1;
    tick(k);
    stop = 1;
    push_a(hi, lo);
    wait_idle();
    chk("ovf_clear", ovf, 0);
    start = 0; stop = 0;
    tick(4);
    chk("busy_after", busy, 0);
    chk("valid_after", valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{10, 8'h00, 8'h0A};
    tbl[1] = '{1, 8'h00, 8'h01};
    tbl[2] = '{3, 8'h00, 8'h03};
    tbl[3] = '{255, 8'h00, 8'hFF};
    tbl[4] = '{256, 8'h01, 8'h00};
    tbl[5] = '{700, 8'h02, 8'hBC};
    tbl[6] = '{4660, 8'h12, 8'h34};
    tick(3);
    chk("rst_valid", valid, 0); chk("rst_data", data, 0); chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0); chk("rst_missed", missed, 0);
    chk("rst_valid8", valid8, 0); chk("rst_busy8", busy8, 0); chk("rst_ovf8", ovf8, 0);
    rst = 1;
    tick(2);
    for (int i = 0; i < 7; i++) run_frame(tbl[i].k, tbl[i].hi, tbl[i].lo);
    // back-pressure on the count LSB byte
    @(negedge clk) start = 1;
    tick(10);
    stop = 1;
    push_a(8'h00, 8'h0A);
    wait_valid();
    @(posedge clk);
    set_ready(0);
    tick(1);
    chk("stall_valid", valid, 1);
    chk("stall_data", data, 8'h0A);
    repeat (4) @(posedge clk);
    set_ready(1);
    wait_idle();
    start = 0; stop = 0;
    tick(4);
    // 8-bit counter timeout and overflow hold
    @(negedge clk) start8 = 1;
    push_b(1);
    wait_idle_b();
    chk("ovf8_set", ovf8, 1);
    start8 = 0;
    tick(4);
    chk("ovf8_hold", ovf8, 1);
    start8 = 1;
    tick(5);
    chk("ovf8_clear", ovf8, 0);
    chk("busy8_run", busy8, 1);
    push_b(1);
    wait_idle_b();
    chk("ovf8_set2", ovf8, 1);
    chk("missed8", missed8, 0);
    start8 = 0;
    // stop alone, then start and stop together
    stop = 1;
    repeat (8) begin
      @(negedge clk);
      chk("stop_only_busy", busy, 0);
    end
    stop = 0;
    tick(4);
    @(negedge clk) begin start = 1; stop = 1; end
    tick(5);
    chk("same_cycle_busy", busy, 1);
    stop = 0;
    tick(5);
    stop = 1;
    push_a(8'h00, 8'h0A);
    wait_idle();
    start = 0; stop = 0;
    tick(4);
    // start edge during SEND
    chk("missed_pre", missed, 0);
    @(negedge clk) start = 1;
    tick(10);
    stop = 1;
    set_ready(0);
    push_a(8'h00, 8'h0A);
    wait_valid();
    start = 0;
    tick(3);
    start = 1;
    tick(5);
    chk("missed_set", missed, 1);
    set_ready(1);
    wait_idle();
    start = 0; stop = 0;
    repeat (10) begin
      @(negedge clk);
      chk("no_extra_frame", busy, 0);
    end
    chk("missed_sticky", missed, 1);
    for (int i = 0; i < 16; i++) run_frame(i + 2, 8'h00, 8'(i + 2));
    // reset mid-SEND
    @(negedge clk) start = 1;
    tick(10);
    stop = 1;
    set_ready(0);
    push_a(8'h00, 8'h0A);
    wait_valid();
    start = 0; stop = 0;
    tick(4);
    @(posedge clk);
    #1 rst = 0;
    q.delete();
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("post_rst_valid", valid, 0); chk("post_rst_busy", busy, 0);
    chk("post_rst_data", data, 0); chk("post_rst_missed", missed, 0);
    seq_a = 0;
    set_ready(1);
    run_frame(5, 8'h00, 8'h05);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
